// File: rtl/sequencer.sv
// Maximal-length Fibonacci LFSR PN generator; the state register drives data directly.
// Latency: zero from state to data; the first advance happens on the edge after the 2-flop release sync.
// Backpressure: none; no enable and no handshake, so the LFSR advances every cycle out of reset.
// Optional feature: define SEQUENCER_PERIOD_FLAG_EN to add the registered 'wrap' output (data == SEED).
module sequencer #(
  parameter int BITS_WIDTH = 5,
  parameter int SEED       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef SEQUENCER_PERIOD_FLAG_EN
  output logic                  wrap,
`endif
  output logic [BITS_WIDTH-1:0] data
);

  // Only widths with a listed maximal-length tap set are supported.
  if (BITS_WIDTH < 3 || BITS_WIDTH > 16) begin : g_bad_width
    $error("sequencer: BITS_WIDTH must be within 3..16");
  end

  // Tap masks: tap t maps to state bit t-1.
  function automatic logic [15:0] f_taps(input int w);
    case (w)
      3:       f_taps = 16'h0006;
      4:       f_taps = 16'h000C;
      5:       f_taps = 16'h0014;
      6:       f_taps = 16'h0030;
      7:       f_taps = 16'h0060;
      8:       f_taps = 16'h00B8;
      9:       f_taps = 16'h0110;
      10:      f_taps = 16'h0240;
      11:      f_taps = 16'h0500;
      12:      f_taps = 16'h0829;
      13:      f_taps = 16'h100D;
      14:      f_taps = 16'h2015;
      15:      f_taps = 16'h6000;
      16:      f_taps = 16'hD008;
      default: f_taps = 16'h0000;
    endcase
  endfunction

  localparam logic [15:0]           L_TAPS_FULL = f_taps(BITS_WIDTH);
  localparam logic [BITS_WIDTH-1:0] L_TAPS      = L_TAPS_FULL[BITS_WIDTH-1:0];
  localparam logic [BITS_WIDTH-1:0] L_SEED_RAW  = SEED[BITS_WIDTH-1:0];
  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [BITS_WIDTH-1:0] L_SEED      =
    (L_SEED_RAW == '0) ? {{(BITS_WIDTH-1){1'b0}}, 1'b1} : L_SEED_RAW;

  logic [1:0]            r_rst_sync;
  logic [BITS_WIDTH-1:0] r_state;
  logic [BITS_WIDTH-1:0] w_next;
  logic                  w_fb;
  logic                  w_run;

  // Reset asserts asynchronously; its release is synchronised through two flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_run = r_rst_sync[1];

  // Next state: shift in the tap XOR, or recover to SEED from the illegal zero state.
  always_comb begin
    w_fb   = ^(r_state & L_TAPS);
    w_next = {r_state[BITS_WIDTH-2:0], w_fb};
    if (r_state == '0) begin
      w_next = L_SEED;
    end
  end

  // State register: SEED in reset, advances each edge once the release has been synchronised.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= L_SEED;
    end else if (w_run) begin
      r_state <= w_next;
    end
  end

  assign data = r_state;

`ifdef SEQUENCER_PERIOD_FLAG_EN
  logic r_wrap;

  // Flag registered alongside the state so it is high exactly while data equals SEED.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrap <= 1'b1;
    end else if (w_run) begin
      r_wrap <= (w_next == L_SEED);
    end
  end

  assign wrap = r_wrap;
`endif

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for sequencer: W=5 reference table, seed override, width sweeps, mid-run reset.
module tb_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  d5_s1, d5_s0, d5_s5;
  logic [2:0]  d3;
  logic [7:0]  d8;
  logic [15:0] d16;
`ifdef SEQUENCER_PERIOD_FLAG_EN
  logic wr5_s1, wr5_s0, wr5_s5, wr3, wr8, wr16;
`endif

`ifdef SEQUENCER_PERIOD_FLAG_EN
  sequencer #(.BITS_WIDTH(5),  .SEED(1)) u_w5_s1 (.clk(clk), .rst(rst), .wrap(wr5_s1), .data(d5_s1));
  sequencer #(.BITS_WIDTH(5),  .SEED(0)) u_w5_s0 (.clk(clk), .rst(rst), .wrap(wr5_s0), .data(d5_s0));
  sequencer #(.BITS_WIDTH(5),  .SEED(5)) u_w5_s5 (.clk(clk), .rst(rst), .wrap(wr5_s5), .data(d5_s5));
  sequencer #(.BITS_WIDTH(3),  .SEED(1)) u_w3    (.clk(clk), .rst(rst), .wrap(wr3),    .data(d3));
  sequencer #(.BITS_WIDTH(8),  .SEED(1)) u_w8    (.clk(clk), .rst(rst), .wrap(wr8),    .data(d8));
  sequencer #(.BITS_WIDTH(16), .SEED(1)) u_w16   (.clk(clk), .rst(rst), .wrap(wr16),   .data(d16));
`else
  sequencer #(.BITS_WIDTH(5),  .SEED(1)) u_w5_s1 (.clk(clk), .rst(rst), .data(d5_s1));
  sequencer #(.BITS_WIDTH(5),  .SEED(0)) u_w5_s0 (.clk(clk), .rst(rst), .data(d5_s0));
  sequencer #(.BITS_WIDTH(5),  .SEED(5)) u_w5_s5 (.clk(clk), .rst(rst), .data(d5_s5));
  sequencer #(.BITS_WIDTH(3),  .SEED(1)) u_w3    (.clk(clk), .rst(rst), .data(d3));
  sequencer #(.BITS_WIDTH(8),  .SEED(1)) u_w8    (.clk(clk), .rst(rst), .data(d8));
  sequencer #(.BITS_WIDTH(16), .SEED(1)) u_w16   (.clk(clk), .rst(rst), .data(d16));
`endif

  // Hand-computed W=5 taps{5,3} sequence from seed 1; index = number of advances.
  int tbl5 [0:30] = '{1, 2, 4, 9, 18, 5, 11, 22, 12, 25, 19, 7, 15, 31, 30, 28,
                      24, 17, 3, 6, 13, 27, 23, 14, 29, 26, 21, 10, 20, 8, 16};
  // Hand-computed W=3 taps{3,2} sequence from seed 1.
  int tbl3 [0:6]  = '{1, 2, 5, 3, 7, 6, 4};

  int n_err = 0;
  int n_chk = 0;

  bit seen3  [0:7];
  bit seen8  [0:255];
  bit seen16 [0:65535];
  int z3 = 0, z8 = 0, z16 = 0;
  int r3 = 0, r8 = 0, r16 = 0;
  int wbad = 0;
  int adv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_w5_s1", 32'(d5_s1), 1);
    chk("rst_w5_s0", 32'(d5_s0), 1);
    chk("rst_w5_s5", 32'(d5_s5), 5);
    chk("rst_w3",    32'(d3),    1);
    chk("rst_w8",    32'(d8),    1);
    chk("rst_w16",   32'(d16),   1);
`ifdef SEQUENCER_PERIOD_FLAG_EN
    chk("rst_wrap",  32'(wr5_s1), 1);
`endif

    // Release: two sync edges during which SEED is held
    rst = 1'b1;
    step();
    step();
    chk("sync_hold_w5", 32'(d5_s1), 1);
    chk("sync_hold_w16", 32'(d16), 1);
`ifdef SEQUENCER_PERIOD_FLAG_EN
    chk("sync_hold_wrap", 32'(wr5_s1), 1);
`endif

    seen3[1]  = 1'b1;
    seen8[1]  = 1'b1;
    seen16[1] = 1'b1;

    for (int k = 1; k <= 65535; k++) begin
      step();
      if (k <= 62) chk("w5_s1_seq", 32'(d5_s1), 32'(tbl5[k % 31]));
      if (k <= 31) begin
        chk("w5_s0_seq", 32'(d5_s0), 32'(tbl5[k % 31]));
        chk("w5_s5_seq", 32'(d5_s5), 32'(tbl5[(k + 5) % 31]));
      end
      if (k < 7) chk("w3_seq", 32'(d3), 32'(tbl3[k]));

      if (k < 7) begin
        if (d3 == 3'd0) z3++;
        if (seen3[d3]) r3++;
        seen3[d3] = 1'b1;
      end else if (k == 7) begin
        chk("w3_period", 32'(d3), 1);
      end
      if (k < 255) begin
        if (d8 == 8'd0) z8++;
        if (seen8[d8]) r8++;
        seen8[d8] = 1'b1;
      end else if (k == 255) begin
        chk("w8_period", 32'(d8), 1);
      end
      if (k < 65535) begin
        if (d16 == 16'd0) z16++;
        if (seen16[d16]) r16++;
        seen16[d16] = 1'b1;
      end else begin
        chk("w16_period", 32'(d16), 1);
      end

`ifdef SEQUENCER_PERIOD_FLAG_EN
      if (k == 30) chk("wrap_c30", 32'(wr5_s1), 0);
      if (k == 31) chk("wrap_c31", 32'(wr5_s1), 1);
      if (k == 32) chk("wrap_c32", 32'(wr5_s1), 0);
      if (k == 62) chk("wrap_c62", 32'(wr5_s1), 1);
      if (wr5_s1 !== (k % 31 == 0))    wbad++;
      if (wr5_s0 !== (k % 31 == 0))    wbad++;
      if (wr5_s5 !== (k % 31 == 0))    wbad++;
      if (wr3    !== (k % 7 == 0))     wbad++;
      if (wr8    !== (k % 255 == 0))   wbad++;
      if (wr16   !== (k % 65535 == 0)) wbad++;
`endif
    end

    chk("w3_zero",    32'(z3),  0);
    chk("w3_repeat",  32'(r3),  0);
    chk("w8_zero",    32'(z8),  0);
    chk("w8_repeat",  32'(r8),  0);
    chk("w16_zero",   32'(z16), 0);
    chk("w16_repeat", 32'(r16), 0);
`ifdef SEQUENCER_PERIOD_FLAG_EN
    chk("wrap_pattern", 32'(wbad), 0);
`endif

    // Mid-run reset: half-cycle low pulse between edges
    adv = 65535;
    repeat (20) step();
    adv += 20;
    chk("pre_midrst", 32'(d5_s1), 32'(tbl5[adv % 31]));
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_w5_s1", 32'(d5_s1), 1);
    chk("midrst_w5_s5", 32'(d5_s5), 5);
    chk("midrst_w16",   32'(d16),   1);
`ifdef SEQUENCER_PERIOD_FLAG_EN
    chk("midrst_wrap",  32'(wr5_s1), 1);
`endif
    #4 rst = 1'b1;
    @(negedge clk);
    chk("midrst_hold0", 32'(d5_s1), 1);
    step();
    chk("midrst_hold1", 32'(d5_s1), 1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("midrst_seq", 32'(d5_s1), 32'(tbl5[k]));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
